// File: rtl/jesd_ramp_checker_pkg.sv
// Shared types and widths for the JESD ramp checker.
package jesd_ramp_checker_pkg;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned RELOCK_CNT_W = 16;
  localparam int unsigned IDX_W        = 16;
  localparam int unsigned BAD_W        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    CHECK   = 2'd2
  } state_e;

endpackage

// File: rtl/jesd_ramp_checker_beat_cmp.sv
// Stage-2 compare: checks one registered beat against the ramp starting at base.
module jesd_ramp_checker_beat_cmp
  import jesd_ramp_checker_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SAMPLES_PER_CH = 2,
  parameter int unsigned NP             = 16
) (
  input  logic [NP-1:0]                         base,
  input  logic [NUM_CH-1:0]                     enable,
  input  logic [NUM_CH*SAMPLES_PER_CH*NP-1:0]   data,
  output logic [NUM_CH*SAMPLES_PER_CH-1:0]      mism_vec,
  output logic [IDX_W-1:0]                      first_idx,
  output logic [NP-1:0]                         first_exp,
  output logic [NP-1:0]                         first_act
);

  localparam int unsigned NS = NUM_CH * SAMPLES_PER_CH;

  logic [NP-1:0] exp_arr [NS];

  // Expected value of sample (i,j) is base + NUM_CH*j + i, wrapping at 2^NP.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      for (int j = 0; j < int'(SAMPLES_PER_CH); j++) begin
        exp_arr[SAMPLES_PER_CH*i + j] = base + NP'(NUM_CH*j + i);
      end
    end
  end

  // Per-sample mismatch, masked by the channel enable.
  always_comb begin
    mism_vec = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      for (int j = 0; j < int'(SAMPLES_PER_CH); j++) begin
        mism_vec[SAMPLES_PER_CH*i + j] = enable[i] &&
          (data[NP*(SAMPLES_PER_CH*i + j) +: NP] != exp_arr[SAMPLES_PER_CH*i + j]);
      end
    end
  end

  // Lowest flat index wins: scan downward so the last hit is the smallest.
  always_comb begin
    first_idx = '0;
    first_exp = '0;
    first_act = '0;
    for (int k = int'(NS) - 1; k >= 0; k--) begin
      if (mism_vec[k]) begin
        first_idx = IDX_W'(k);
        first_exp = exp_arr[k];
        first_act = data[NP*k +: NP];
      end
    end
  end

endmodule

// File: rtl/jesd_ramp_checker.sv
// JESD RX ramp-pattern checker with lock tracking and error counters.
// Optional first-error capture: define JESD_RAMP_CHECKER_CAPTURE_EN.
module jesd_ramp_checker
  import jesd_ramp_checker_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SAMPLES_PER_CH = 2,
  parameter int unsigned NP             = 16,
  parameter int unsigned RELOCK_THRESH  = 4
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 check_en,
  input  logic                                 err_clr,
  input  logic                                 adc_valid,
  input  logic [NUM_CH-1:0]                    adc_enable,
  input  logic [NUM_CH*SAMPLES_PER_CH*NP-1:0]  adc_data,
  output logic                                 locked,
  output logic [CNT_W-1:0]                     error_cnt,
  output logic [CNT_W-1:0]                     beat_cnt,
  output logic [RELOCK_CNT_W-1:0]              relock_cnt,
  output logic                                 mismatch,
  output logic [NP-1:0]                        first_err_exp,
  output logic [NP-1:0]                        first_err_act,
  output logic [IDX_W-1:0]                     first_err_idx
);

  localparam int unsigned NS   = NUM_CH * SAMPLES_PER_CH;
  localparam int unsigned DW   = NS * NP;
  localparam logic [NP-1:0] STEP = NP'(NS);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(RELOCK_THRESH - 1);

  state_e            state_q, state_d;
  logic              s1_valid;
  logic [DW-1:0]     s1_data;
  logic [NUM_CH-1:0] s1_enable;
  logic [NP-1:0]     base_q;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              beat_fire_c;
  logic              relock_c;
  logic              any_mism_c;
  logic [NP-1:0]     cmp_base_c;
  logic [NS-1:0]     cmp_vec;
  logic [IDX_W-1:0]  cmp_idx;
  logic [NP-1:0]     cmp_exp;
  logic [NP-1:0]     cmp_act;

  // Stage 1: register the beat; only beats arriving while armed enter the pipe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_enable <= '0;
    end else begin
      s1_valid <= adc_valid && check_en && (state_q != IDLE);
      if (adc_valid) begin
        s1_data   <= adc_data;
        s1_enable <= adc_enable;
      end
    end
  end

  // The seeding beat compares against its own sample (0,0).
  assign cmp_base_c = (state_q == ACQUIRE) ? s1_data[NP-1:0] : base_q;
  assign any_mism_c = |cmp_vec;

  jesd_ramp_checker_beat_cmp #(
    .NUM_CH         (NUM_CH),
    .SAMPLES_PER_CH (SAMPLES_PER_CH),
    .NP             (NP)
  ) u_beat_cmp (
    .base      (cmp_base_c),
    .enable    (s1_enable),
    .data      (s1_data),
    .mism_vec  (cmp_vec),
    .first_idx (cmp_idx),
    .first_exp (cmp_exp),
    .first_act (cmp_act)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
    end
  end

  // Next state, consecutive-bad tracking and per-beat strobes.
  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    beat_fire_c = 1'b0;
    relock_c    = 1'b0;
    if (!check_en) begin
      state_d = IDLE;
      bad_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (s1_valid && s1_enable[0]) begin
            beat_fire_c = 1'b1;
            state_d     = CHECK;
            bad_d       = '0;
          end
        end
        CHECK: begin
          if (s1_valid) begin
            beat_fire_c = 1'b1;
            if (any_mism_c) begin
              if (bad_q == BAD_LAST) begin
                state_d  = ACQUIRE;
                relock_c = 1'b1;
                bad_d    = '0;
              end else begin
                bad_d = bad_q + BAD_W'(1);
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage 2 results: ramp base, lock flag, pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_q     <= '0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      beat_cnt   <= '0;
      error_cnt  <= '0;
      relock_cnt <= '0;
    end else begin
      locked   <= (state_d == CHECK);
      mismatch <= beat_fire_c && any_mism_c;
      if (beat_fire_c) begin
        base_q <= cmp_base_c + STEP;
      end
      if (beat_fire_c && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (err_clr) begin
        error_cnt <= '0;
      end else if (beat_fire_c && any_mism_c && (error_cnt != '1)) begin
        error_cnt <= error_cnt + CNT_W'(1);
      end
      if (err_clr) begin
        relock_cnt <= '0;
      end else if (relock_c && (relock_cnt != '1)) begin
        relock_cnt <= relock_cnt + RELOCK_CNT_W'(1);
      end
    end
  end

`ifdef JESD_RAMP_CHECKER_CAPTURE_EN
  logic cap_done_q;

  // Latch the first mismatching sample; err_clr re-arms.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_done_q    <= 1'b0;
      first_err_exp <= '0;
      first_err_act <= '0;
      first_err_idx <= '0;
    end else if (err_clr) begin
      cap_done_q    <= 1'b0;
      first_err_exp <= '0;
      first_err_act <= '0;
      first_err_idx <= '0;
    end else if (beat_fire_c && any_mism_c && !cap_done_q) begin
      cap_done_q    <= 1'b1;
      first_err_exp <= cmp_exp;
      first_err_act <= cmp_act;
      first_err_idx <= cmp_idx;
    end
  end
`else
  logic cap_unused;

  // Capture disabled: report constant zero.
  assign first_err_exp = '0;
  assign first_err_act = '0;
  assign first_err_idx = '0;
  assign cap_unused    = ^{cmp_idx, cmp_exp, cmp_act};
`endif

endmodule

// File: doc/jesd_ramp_checker.md
JESD_RAMP_CHECKER -- requirements
Module: jesd_ramp_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: converters per link (M).
REQ-002 SHALL have parameter SAMPLES_PER_CH, default 2: samples per channel per beat.
REQ-003 SHALL have parameter NP, default 16: sample width in bits (DMA-widened).
REQ-004 SHALL have parameter RELOCK_THRESH, default 4: consecutive bad beats that force re-acquire (range 1..255).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  sample clock (RX device clock domain); resetn  in  1  synchronous active-low reset.
REQ-006 SHALL have these ports:
- check_en  in  1  enables checking.
- err_clr  in  1  clears error_cnt and relock_cnt.
- adc_valid  in  1  beat qualifier.
- adc_enable  in  NUM_CH  per-channel enable.
- adc_data  in  NUM_CH*SAMPLES_PER_CH*NP  flat beat; sample (i,j) occupies bits NP*(SAMPLES_PER_CH*i+j) +: NP.
- locked  out  1  ramp acquired.
- error_cnt  out  32  mismatched beats.
- beat_cnt  out  32  checked beats.
- relock_cnt  out  16  lock losses.
- mismatch  out  1  one-cycle pulse per bad beat.
- first_err_exp  out  NP  expected value of first mismatch.
- first_err_act  out  NP  actual value of first mismatch.
- first_err_idx  out  16  flat sample index of first mismatch.

Function
REQ-007 SHALL check that sample(i,j) equals base + NUM_CH*j + i, modulo 2^NP.
REQ-008 SHALL advance the expected base by NUM_CH*SAMPLES_PER_CH, modulo 2^NP, after every checked beat; wrap past 2^NP-1 is legal.
REQ-009 SHALL skip comparison for samples of any channel whose adc_enable bit is 0.
REQ-010 SHALL implement states IDLE, ACQUIRE, CHECK.
- IDLE->ACQUIRE when check_en=1.
- Any state->IDLE when check_en=0; locked clears the next cycle.
REQ-011 In ACQUIRE, on a beat with adc_valid=1 and adc_enable[0]=1, SHALL seed base = sample(0,0), check the remaining samples against that seed, and go to CHECK; beats with adc_enable[0]=0 are ignored.
REQ-012 In CHECK, on a beat with adc_valid=1:
- any mismatch: increment error_cnt, pulse mismatch, increment the consecutive-bad counter.
- clean beat: reset the consecutive-bad counter.
- every checked beat increments beat_cnt.
REQ-013 When the consecutive-bad counter reaches RELOCK_THRESH, SHALL go to ACQUIRE, clear locked, and increment relock_cnt.
REQ-014 SHALL use a two-stage pipeline: beat registered in stage 1, compared in stage 2.
- counters, mismatch and locked update 2 cycles after the adc_valid edge.
- locked rises 2 cycles after the seeding beat.
REQ-015 SHALL ignore adc_data and hold all state when adc_valid=0.
REQ-016 error_cnt and beat_cnt SHALL saturate at 0xFFFFFFFF; relock_cnt SHALL saturate at 0xFFFF.
REQ-017 err_clr SHALL zero error_cnt and relock_cnt and re-arm the first-error capture.
- err_clr wins over a same-cycle increment.
- err_clr does not affect the FSM or locked.

Reset
REQ-018 While resetn=0 at a clk edge:
- state, pipeline valid bits and the consecutive-bad counter SHALL go to IDLE/0.
- every output SHALL be 0.
REQ-019 Reset mid-CHECK SHALL discard in-flight pipeline beats; no count update from them occurs.

Configuration
REQ-020 With JESD_RAMP_CHECKER_CAPTURE_EN defined:
- the first mismatching sample after reset or err_clr (lowest flat index within its beat) SHALL be latched into first_err_exp, first_err_act and first_err_idx.
- these hold until the next err_clr or reset.
REQ-021 Without JESD_RAMP_CHECKER_CAPTURE_EN, first_err_exp, first_err_act and first_err_idx SHALL be constant 0 and the capture logic SHALL be absent.

Structure
REQ-022 Package jesd_ramp_checker_pkg SHALL hold:
- the state enum (IDLE, ACQUIRE, CHECK).
- the counter width constants (32, 16).
REQ-023 Sub-module jesd_ramp_checker_beat_cmp SHALL implement the stage-2 compare.
- outputs: per-sample mismatch vector, lowest mismatching index, and its expected/actual values.
- all other logic stays in the top.

Verification (NUM_CH=4, SAMPLES_PER_CH=2, NP=16, RELOCK_THRESH=4)
REQ-024 Ramp seeded at 0x0010, 8 consecutive beats, all channels enabled -> locked=1 two cycles after beat 1, error_cnt=0, beat_cnt=8.
REQ-025 Seed 0xFFF8, 3 beats (second beat expects 0x0000..0x0007) -> error_cnt=0, no mismatch pulse.
REQ-026 Beat 3 sample(2,1) forced to 0xDEAD, seed 0x0000 -> error_cnt=1, one mismatch pulse, locked stays 1; with capture enabled: first_err_exp=0x0016, first_err_act=0xDEAD, first_err_idx=5.
REQ-027 4 consecutive all-zero beats after lock at seed 0x0100 -> relock_cnt=1, locked=0; next clean beat -> locked=1 again.
REQ-028 adc_enable=4'b0111 with random data on channel 3 -> error_cnt=0 over 16 beats.
REQ-029 resetn=0 for one cycle mid-CHECK with error_cnt=3 -> all outputs 0, state IDLE; ACQUIRE re-entered only while check_en=1.
